// File: rtl/pio_out_arbiter.sv
// Round-robin arbiter sharing the single Avalon-MM write port of a PIO output
// register among NUM_REQ requesters; keeps a shadow of the last value written.
module pio_out_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 0,
  localparam int OWNER_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [1:0]                avm_address,
  output logic                      avm_chipselect,
  output logic                      avm_write_n,
  output logic [31:0]               avm_writedata,
  output logic [OWNER_W-1:0]        owner,
  output logic                      busy,
  output logic [DATA_W-1:0]         shadow
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_e;

  localparam logic [7:0]         GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [OWNER_W-1:0] LAST_INIT = OWNER_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [OWNER_W-1:0]   last_q, last_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]    cap_q, cap_d;
  logic [DATA_W-1:0]    shadow_q, shadow_d;
  logic [7:0]           gap_q, gap_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 busy_q, busy_d;

  logic                 grant_vld;
  logic [OWNER_W-1:0]   grant_idx;

  // Search from last+1 upward; index wraps modulo NUM_REQ, not 2^OWNER_W.
  always_comb begin : arb
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req[OWNER_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = OWNER_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cap_d    = cap_q;
    shadow_d = shadow_q;
    gap_d    = gap_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_WRITE;
          last_d  = grant_idx;
          owner_d = grant_idx;
          cap_d   = req_data[int'(grant_idx)*DATA_W +: DATA_W];
        end
      end
      S_WRITE: begin
        shadow_d = cap_q;
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    cs_d    = (state_d == S_WRITE);
    wn_d    = ~cs_d;
    ack_d   = cs_d ? (NUM_REQ'(1) << owner_d) : '0;
    wdata_d = cs_d ? 32'(cap_d) : 32'd0;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= LAST_INIT;
      owner_q  <= '0;
      cap_q    <= '0;
      shadow_q <= '0;
      gap_q    <= '0;
      ack_q    <= '0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      wdata_q  <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cap_q    <= cap_d;
      shadow_q <= shadow_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign ack            = ack_q;
  assign avm_address    = 2'b00;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wdata_q;
  assign owner          = owner_q;
  assign busy           = busy_q;
  assign shadow         = shadow_q;

endmodule
